// File: rtl/piso_rr_serializer.sv
// Round-robin arbiter in front of one shared parallel-in/serial-out datapath.
// Each granted word leaves MSB first as a framed burst, tagged with its owner's ID.
module piso_rr_serializer #(
    parameter int  NUM_REQ    = 4,
    parameter int  WIDTH      = 4,
    parameter int  GAP_CYCLES = 0,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       sout,
    output logic                       sframe,
    output logic [IDW-1:0]             sid,
    output logic                       busy
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic               sout_q, sout_d;
    logic               sframe_q, sframe_d;
    logic [IDW-1:0]     sid_q, sid_d;
    logic               busy_q, busy_d;

    logic               grant_s;
    logic [IDW-1:0]     grant_idx_s;
    logic [WIDTH-1:0]   sel_word_s;
    logic [NUM_REQ-1:0] req_ready_s;

    // First valid requester after the previous winner, wrapping around.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDW-1:0]     last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Arbitration, winner's word select and the one-hot accept strobe.
    always_comb begin
        grant_idx_s = rr_pick(req_valid, last_grant_q);
        grant_s     = rst && en && (state_q == ST_IDLE) && (|req_valid);
        sel_word_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == grant_idx_s) begin
                sel_word_s = req_data[i*WIDTH +: WIDTH];
            end else begin
                sel_word_s = sel_word_s;
            end
        end
        req_ready_s = '0;
        if (grant_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Load/shift/gap sequencing and next values of the serial outputs.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        gcnt_d       = gcnt_q;
        last_grant_d = last_grant_q;
        sout_d       = sout_q;
        sframe_d     = sframe_q;
        sid_d        = sid_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    // The MSB leaves on the load edge, so only WIDTH-1 shifts remain.
                    shreg_d      = {sel_word_s[WIDTH-2:0], 1'b0};
                    sout_d       = sel_word_s[WIDTH-1];
                    sframe_d     = 1'b1;
                    sid_d        = grant_idx_s;
                    last_grant_d = grant_idx_s;
                    cnt_d        = CW'(WIDTH - 1);
                    state_d      = ST_SHIFT;
                end else begin
                    sout_d   = 1'b0;
                    sframe_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    sout_d  = shreg_q[WIDTH-1];
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - CW'(1);
                end else begin
                    sout_d   = 1'b0;
                    sframe_d = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        gcnt_d  = GW'(GAP_CYCLES - 1);
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                sout_d   = 1'b0;
                sframe_d = 1'b0;
                if (gcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sout_d   = 1'b0;
                sframe_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; a low rst abandons any frame at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            gcnt_q       <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            sout_q       <= 1'b0;
            sframe_q     <= 1'b0;
            sid_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            gcnt_q       <= gcnt_d;
            last_grant_q <= last_grant_d;
            sout_q       <= sout_d;
            sframe_q     <= sframe_d;
            sid_q        <= sid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready = req_ready_s;
    assign sout      = sout_q;
    assign sframe    = sframe_q;
    assign sid       = sid_q;
    assign busy      = busy_q;

endmodule
